// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: the address map, the
// access operation encoding, status and interrupt bit positions, interrupt
// causes, WARL masks and the read-modify-write helper.
package csr_pkg;

   // CSR address map
   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   // Access operation driven by the decoder
   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'd0,
      CSR_OP_RW   = 2'd1,
      CSR_OP_RS   = 2'd2,
      CSR_OP_RC   = 2'd3
   } csr_op_t;

   // mstatus bit positions
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   // mip / mie bit positions
   localparam int MIP_MSIP = 3;
   localparam int MIP_MTIP = 7;
   localparam int MIP_MEIP = 11;

   // Interrupt cause codes (bit 31 marks an interrupt)
   localparam logic [31:0] CAUSE_IRQ_SW    = 32'h8000_0003;
   localparam logic [31:0] CAUSE_IRQ_TIMER = 32'h8000_0007;
   localparam logic [31:0] CAUSE_IRQ_EXT   = 32'h8000_000B;

   // WARL masks: bits set are writable / kept
   localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;  // MPP hardwired to M-mode
   localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
   localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
   localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFD;
   localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;

   // Read-modify-write result before WARL masking
   function automatic logic [31:0] csr_apply_op(input csr_op_t op,
                                                input logic [31:0] old_val,
                                                input logic [31:0] operand);
      logic [31:0] res;
      unique case (op)
         CSR_OP_RW: res = operand;
         CSR_OP_RS: res = old_val | operand;
         CSR_OP_RC: res = old_val & ~operand;
         default:   res = old_val;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/csr_unit_counter.sv
// Free-running counter with independently writable low and high halves.
// Used for mcycle and minstret; COUNTER_W must lie in 33..64.
module csr_counter #(
   parameter int COUNTER_W = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 lo_we,
   input  logic                 hi_we,
   input  logic [31:0]          wdata,
   input  logic                 inc,
   output logic [COUNTER_W-1:0] count
);

   localparam int HI_W = COUNTER_W - 32;

   // A software write to either half takes precedence over counting that cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (lo_we || hi_we) begin
         if (lo_we) count[31:0] <= wdata;
         if (hi_we) count[COUNTER_W-1:32] <= wdata[HI_W-1:0];
      end else if (inc) begin
         // Full-width add: low-half overflow carries into the high half,
         // and the all-ones value wraps to zero.
         count <= count + COUNTER_W'(1);
      end
   end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: decodes CSR accesses from the execute stage,
// applies RW/RS/RC with WARL masking, flags illegal accesses, performs
// trap-entry and MRET status updates, tracks interrupt pending state and
// keeps the 64-bit cycle and retired-instruction counters.
module csr_unit
   import csr_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              COUNTER_W   = 64,
   parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [XLEN-1:0] MISA_VALUE  = 32'h4000_0100
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            csr_en,
   input  logic [1:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            instret,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret,
   input  logic            irq_sw,
   input  logic            irq_timer,
   input  logic            irq_ext,
   output logic            irq_pending,
   output logic [XLEN-1:0] irq_cause,
   output logic [XLEN-1:0] trap_vector,
   output logic [XLEN-1:0] mepc_o
);

   csr_op_t         op;
   logic            st_mie;
   logic            st_mpie;
   logic [XLEN-1:0] mstatus_val;
   logic [XLEN-1:0] mie_q;
   logic [XLEN-1:0] mip_q;
   logic [XLEN-1:0] mscratch_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] mcause_q;
   logic [XLEN-1:0] mtvec_q;
   logic [COUNTER_W-1:0] mcycle_cnt;
   logic [COUNTER_W-1:0] minstret_cnt;

   logic [XLEN-1:0] rd_val;
   logic            mapped;
   logic            read_only;
   logic            ro_write;
   logic            wr_en;
   logic [XLEN-1:0] new_val;
   logic            mret_eff;
   logic [XLEN-1:0] irq_act;
   logic [XLEN-1:0] tvec_base;

   assign op = csr_op_t'(csr_op);

   // Only MIE and MPIE are stored; the rest of mstatus is constant
   assign mstatus_val = MSTATUS_FIXED
                      | (XLEN'(st_mpie) << MSTATUS_MPIE)
                      | (XLEN'(st_mie)  << MSTATUS_MIE);

   // Address decode and current-value read mux
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      rd_val = '0;
      mapped = 1'b1;
      unique case (csr_addr)
         CSR_MSTATUS:   rd_val = mstatus_val;
         CSR_MISA:      rd_val = MISA_VALUE;
         CSR_MIE:       rd_val = mie_q;
         CSR_MTVEC:     rd_val = mtvec_q;
         CSR_MSCRATCH:  rd_val = mscratch_q;
         CSR_MEPC:      rd_val = mepc_q;
         CSR_MCAUSE:    rd_val = mcause_q;
         CSR_MIP:       rd_val = mip_q;
         CSR_MCYCLE:    rd_val = mcycle_cnt[XLEN-1:0];
         CSR_MINSTRET:  rd_val = minstret_cnt[XLEN-1:0];
         CSR_MCYCLEH:   rd_val = XLEN'(mcycle_cnt >> 32);
         CSR_MINSTRETH: rd_val = XLEN'(minstret_cnt >> 32);
         CSR_MHARTID:   rd_val = '0;
         default:       mapped = 1'b0;
      endcase
   end

   // Legality: unmapped, or a modifying access to a read-only CSR
   assign read_only   = (csr_addr[11:10] == 2'b11) || (csr_addr == CSR_MISA);
   assign ro_write    = (op == CSR_OP_RW) ||
                        (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (|csr_wdata));
   assign csr_illegal = csr_en && (!mapped || (read_only && ro_write));
   assign csr_rdata   = (csr_en && mapped) ? rd_val : '0;

   // RS/RC with a zero operand on a writable CSR rewrites the old value, which is harmless
   assign wr_en    = csr_en && !csr_illegal && (op != CSR_OP_NONE) && !read_only;
   assign new_val  = csr_apply_op(op, rd_val, csr_wdata);
   assign mret_eff = mret && !trap_valid;

   // mstatus: trap entry beats MRET, which beats a software write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_mie  <= 1'b0;
         st_mpie <= 1'b0;
      end else if (trap_valid) begin
         // NOTE: non-blocking assignments make both updates read the pre-edge values.
         st_mpie <= st_mie;
         st_mie  <= 1'b0;
      end else if (mret_eff) begin
         st_mie  <= st_mpie;
         st_mpie <= 1'b1;
      end else if (wr_en && (csr_addr == CSR_MSTATUS)) begin
         st_mie  <= new_val[MSTATUS_MIE];
         st_mpie <= new_val[MSTATUS_MPIE];
      end
   end

   // mepc / mcause: captured on trap entry, otherwise software-writable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mepc_q   <= '0;
         mcause_q <= '0;
      end else if (trap_valid) begin
         mepc_q   <= trap_pc & MEPC_WMASK;
         mcause_q <= trap_cause;
      end else if (wr_en) begin
         if (csr_addr == CSR_MEPC)   mepc_q   <= new_val & MEPC_WMASK;
         if (csr_addr == CSR_MCAUSE) mcause_q <= new_val;
      end
   end

   // CSRs untouched by trap/MRET: software writes always land
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RESET & MTVEC_WMASK;
         mscratch_q <= '0;
      end else if (wr_en) begin
         if (csr_addr == CSR_MIE)      mie_q      <= new_val & MIE_WMASK;
         if (csr_addr == CSR_MTVEC)    mtvec_q    <= new_val & MTVEC_WMASK;
         if (csr_addr == CSR_MSCRATCH) mscratch_q <= new_val;
      end
   end

   // mip mirrors the interrupt lines with one cycle of latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mip_q <= '0;
      end else begin
         mip_q           <= '0;
         mip_q[MIP_MSIP] <= irq_sw;
         mip_q[MIP_MTIP] <= irq_timer;
         mip_q[MIP_MEIP] <= irq_ext;
      end
   end

   // Interrupt selection: external > software > timer
   assign irq_act     = mip_q & mie_q;
   assign irq_pending = st_mie && (|irq_act);

   always_comb begin
      irq_cause = '0;
      if (irq_act[MIP_MEIP])      irq_cause = CAUSE_IRQ_EXT;
      else if (irq_act[MIP_MSIP]) irq_cause = CAUSE_IRQ_SW;
      else if (irq_act[MIP_MTIP]) irq_cause = CAUSE_IRQ_TIMER;
   end

   // Trap target: vectored mode offsets interrupts by 4*cause
   assign tvec_base = mtvec_q & ~XLEN'(3);

   always_comb begin
      trap_vector = tvec_base;
      if (mtvec_q[0] && trap_cause[XLEN-1])
         trap_vector = tvec_base + XLEN'({trap_cause[4:0], 2'b00});
   end

   assign mepc_o = mepc_q;

   csr_counter #(.COUNTER_W(COUNTER_W)) u_mcycle (
      .clk   (clk),
      .rst_n (rst_n),
      .lo_we (wr_en && (csr_addr == CSR_MCYCLE)),
      .hi_we (wr_en && (csr_addr == CSR_MCYCLEH)),
      .wdata (new_val),
      .inc   (1'b1),
      .count (mcycle_cnt)
   );

   csr_counter #(.COUNTER_W(COUNTER_W)) u_minstret (
      .clk   (clk),
      .rst_n (rst_n),
      .lo_we (wr_en && (csr_addr == CSR_MINSTRET)),
      .hi_we (wr_en && (csr_addr == CSR_MINSTRETH)),
      .wdata (new_val),
      .inc   (instret),
      .count (minstret_cnt)
   );

endmodule

// File: tb/tb_csr_unit.sv
// Directed testbench for csr_unit with hand-computed expected values.
module tb_csr_unit;
   import csr_pkg::*;

   localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_0103;
   localparam logic [31:0] TB_MISA        = 32'h4000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        csr_en;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        instret;
   logic        trap_valid;
   logic [31:0] trap_cause;
   logic [31:0] trap_pc;
   logic        mret;
   logic        irq_sw, irq_timer, irq_ext;
   logic        irq_pending;
   logic [31:0] irq_cause;
   logic [31:0] trap_vector;
   logic [31:0] mepc_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   csr_unit #(
      .XLEN        (32),
      .COUNTER_W   (64),
      .MTVEC_RESET (TB_MTVEC_RESET),
      .MISA_VALUE  (TB_MISA)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .csr_en      (csr_en),
      .csr_op      (csr_op),
      .csr_addr    (csr_addr),
      .csr_wdata   (csr_wdata),
      .csr_rdata   (csr_rdata),
      .csr_illegal (csr_illegal),
      .instret     (instret),
      .trap_valid  (trap_valid),
      .trap_cause  (trap_cause),
      .trap_pc     (trap_pc),
      .mret        (mret),
      .irq_sw      (irq_sw),
      .irq_timer   (irq_timer),
      .irq_ext     (irq_ext),
      .irq_pending (irq_pending),
      .irq_cause   (irq_cause),
      .trap_vector (trap_vector),
      .mepc_o      (mepc_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Combinational read at the current time (no clock edge consumed)
   task automatic peek(input logic [11:0] addr, output logic [31:0] data, output logic ill);
      csr_en = 1'b1; csr_op = CSR_OP_NONE; csr_addr = addr; csr_wdata = '0;
      #1;
      data = csr_rdata; ill = csr_illegal;
      csr_en = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic        i;
      @(negedge clk);
      peek(addr, d, i);
      check(tag, d, exp);
   endtask

   // One CSR access committed at the next rising edge; returns the illegal flag
   task automatic csr_wr(input csr_op_t o, input logic [11:0] addr, input logic [31:0] wd,
                         output logic ill);
      @(negedge clk);
      csr_en = 1'b1; csr_op = o; csr_addr = addr; csr_wdata = wd;
      #1 ill = csr_illegal;
      @(posedge clk);
      #1;
      csr_en = 1'b0; csr_op = CSR_OP_NONE;
   endtask

   initial begin
      logic        ill;
      logic [31:0] d;

      rst_n = 1'b0; csr_en = 1'b0; csr_op = '0; csr_addr = '0; csr_wdata = '0;
      instret = 1'b0; trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; mret = 1'b0;
      irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Reset state
      csr_addr = CSR_MSTATUS; #1;
      check("rdata_when_disabled", csr_rdata, 32'h0);
      check("reset_irq_pending", {31'b0, irq_pending}, 32'h0);
      check("reset_mepc_o", mepc_o, 32'h0);
      rd_chk("reset_mstatus", CSR_MSTATUS, 32'h0000_1800);
      rd_chk("reset_mtvec", CSR_MTVEC, 32'h0000_0101);
      rd_chk("reset_mie", CSR_MIE, 32'h0);
      @(negedge clk); peek(12'h7C0, d, ill);
      check("unmapped_rdata", d, 32'h0);
      check("unmapped_illegal", {31'b0, ill}, 32'h1);

      // mscratch read-modify-write ops
      csr_wr(CSR_OP_RW, CSR_MSCRATCH, 32'hDEAD_BEEF, ill);
      rd_chk("mscratch_rw", CSR_MSCRATCH, 32'hDEAD_BEEF);
      csr_wr(CSR_OP_RS, CSR_MSCRATCH, 32'h0000_0010, ill);
      rd_chk("mscratch_rs", CSR_MSCRATCH, 32'hDEAD_BEFF);
      csr_wr(CSR_OP_RC, CSR_MSCRATCH, 32'h0000_000F, ill);
      rd_chk("mscratch_rc", CSR_MSCRATCH, 32'hDEAD_BEF0);

      // WARL masking and read-only space
      csr_wr(CSR_OP_RW, CSR_MSTATUS, 32'hFFFF_FFFF, ill);
      rd_chk("mstatus_warl", CSR_MSTATUS, 32'h0000_1888);
      csr_wr(CSR_OP_RW, CSR_MSTATUS, 32'h0, ill);
      rd_chk("mstatus_clear", CSR_MSTATUS, 32'h0000_1800);
      csr_wr(CSR_OP_RW, CSR_MHARTID, 32'h1234_5678, ill);
      check("mhartid_rw_illegal", {31'b0, ill}, 32'h1);
      rd_chk("mhartid_value", CSR_MHARTID, 32'h0);
      csr_wr(CSR_OP_RS, CSR_MISA, 32'h0, ill);
      check("misa_rs0_legal", {31'b0, ill}, 32'h0);
      rd_chk("misa_value", CSR_MISA, TB_MISA);
      csr_wr(CSR_OP_RC, CSR_MISA, 32'h1, ill);
      check("misa_rc_illegal", {31'b0, ill}, 32'h1);
      csr_wr(CSR_OP_RW, CSR_MIP, 32'hFFFF_FFFF, ill);
      check("mip_write_legal", {31'b0, ill}, 32'h0);
      rd_chk("mip_readonly", CSR_MIP, 32'h0);
      csr_wr(CSR_OP_RW, CSR_MIE, 32'hFFFF_FFFF, ill);
      rd_chk("mie_warl", CSR_MIE, 32'h0000_0888);
      csr_wr(CSR_OP_RW, CSR_MTVEC, 32'hFFFF_FFFF, ill);
      rd_chk("mtvec_warl", CSR_MTVEC, 32'hFFFF_FFFD);
      csr_wr(CSR_OP_RW, CSR_MEPC, 32'h0000_0123, ill);
      rd_chk("mepc_warl", CSR_MEPC, 32'h0000_0120);

      // Interrupt pending and priority
      csr_wr(CSR_OP_RW, CSR_MSTATUS, 32'h0000_0008, ill);
      csr_wr(CSR_OP_RW, CSR_MIE, 32'h0000_0800, ill);
      @(negedge clk); irq_ext = 1'b1; #1;
      check("irq_latency_pending0", {31'b0, irq_pending}, 32'h0);
      @(posedge clk); #1;
      check("irq_ext_pending", {31'b0, irq_pending}, 32'h1);
      check("irq_ext_cause", irq_cause, 32'h8000_000B);
      csr_wr(CSR_OP_RW, CSR_MIE, 32'h0000_0888, ill);
      @(negedge clk); irq_sw = 1'b1; irq_timer = 1'b1;
      @(posedge clk); #1;
      check("irq_prio_ext", irq_cause, 32'h8000_000B);
      @(negedge clk); irq_ext = 1'b0;
      @(posedge clk); #1;
      check("irq_prio_sw", irq_cause, 32'h8000_0003);
      @(negedge clk); irq_sw = 1'b0;
      @(posedge clk); #1;
      check("irq_prio_timer", irq_cause, 32'h8000_0007);
      @(negedge clk); irq_timer = 1'b0;
      @(posedge clk); #1;
      check("irq_none_pending", {31'b0, irq_pending}, 32'h0);
      check("irq_none_cause", irq_cause, 32'h0);

      // Trap vector
      csr_wr(CSR_OP_RW, CSR_MTVEC, 32'h0000_1001, ill);
      @(negedge clk); trap_cause = 32'h8000_000B; #1;
      check("tvec_vectored_irq", trap_vector, 32'h0000_102C);
      trap_cause = 32'h0000_0002; #1;
      check("tvec_vectored_exc", trap_vector, 32'h0000_1000);
      trap_cause = 32'h8000_000B; irq_ext = 1'b1;

      // Trap with a competing mepc write: trap wins
      @(negedge clk);
      trap_valid = 1'b1; trap_pc = 32'h0000_0203;
      csr_en = 1'b1; csr_op = CSR_OP_RW; csr_addr = CSR_MEPC; csr_wdata = 32'h0000_0500;
      @(posedge clk); #1;
      trap_valid = 1'b0; csr_en = 1'b0; csr_op = CSR_OP_NONE;
      check("trap_mepc_o", mepc_o, 32'h0000_0200);
      check("trap_masks_irq", {31'b0, irq_pending}, 32'h0);
      rd_chk("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);
      rd_chk("trap_mepc", CSR_MEPC, 32'h0000_0200);
      rd_chk("trap_mcause", CSR_MCAUSE, 32'h8000_000B);

      // MRET beats a same-cycle mstatus write
      @(negedge clk);
      mret = 1'b1;
      csr_en = 1'b1; csr_op = CSR_OP_RW; csr_addr = CSR_MSTATUS; csr_wdata = 32'h0;
      @(posedge clk); #1;
      mret = 1'b0; csr_en = 1'b0; csr_op = CSR_OP_NONE;
      check("mret_irq_pending", {31'b0, irq_pending}, 32'h1);
      rd_chk("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

      // Trap and MRET together, plus a write to an unaffected CSR
      @(negedge clk);
      trap_valid = 1'b1; mret = 1'b1; trap_pc = 32'h0000_0300; trap_cause = 32'h0000_0002;
      csr_en = 1'b1; csr_op = CSR_OP_RW; csr_addr = CSR_MSCRATCH; csr_wdata = 32'h0000_0055;
      @(posedge clk); #1;
      trap_valid = 1'b0; mret = 1'b0; csr_en = 1'b0; csr_op = CSR_OP_NONE; irq_ext = 1'b0;
      rd_chk("trapmret_mstatus", CSR_MSTATUS, 32'h0000_1880);
      rd_chk("trapmret_mscratch", CSR_MSCRATCH, 32'h0000_0055);
      rd_chk("trapmret_mepc", CSR_MEPC, 32'h0000_0300);
      rd_chk("trapmret_mcause", CSR_MCAUSE, 32'h0000_0002);

      // mcycle low-half overflow into high half
      csr_wr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF, ill);
      peek(CSR_MCYCLE, d, ill);
      check("mcycle_written", d, 32'hFFFF_FFFF);
      peek(CSR_MCYCLEH, d, ill);
      check("mcycleh_before", d, 32'h0);
      @(posedge clk); #1;
      peek(CSR_MCYCLE, d, ill);
      check("mcycle_carry_lo", d, 32'h0);
      @(posedge clk); #1;
      peek(CSR_MCYCLEH, d, ill);
      check("mcycle_carry_hi", d, 32'h1);

      // mcycle 64-bit wrap
      csr_wr(CSR_OP_RW, CSR_MCYCLEH, 32'hFFFF_FFFF, ill);
      csr_wr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF, ill);
      peek(CSR_MCYCLEH, d, ill);
      check("mcycle_allones_hi", d, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      peek(CSR_MCYCLE, d, ill);
      check("mcycle_wrap_lo", d, 32'h0);
      peek(CSR_MCYCLEH, d, ill);
      check("mcycle_wrap_hi", d, 32'h0);

      // minstret counts instret pulses only
      rd_chk("minstret_start", CSR_MINSTRET, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); instret = 1'b1;
         @(negedge clk); instret = 1'b0;
         @(negedge clk);
      end
      rd_chk("minstret_three", CSR_MINSTRET, 32'h3);
      @(negedge clk); instret = 1'b1;
      csr_en = 1'b1; csr_op = CSR_OP_RW; csr_addr = CSR_MINSTRET; csr_wdata = 32'h0000_0010;
      @(posedge clk); #1;
      instret = 1'b0; csr_en = 1'b0; csr_op = CSR_OP_NONE;
      rd_chk("minstret_write_wins", CSR_MINSTRET, 32'h0000_0010);
      rd_chk("minstreth_zero", CSR_MINSTRETH, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
Parametrised machine-mode CSR unit replacing the flat fixed-address CSR register array. Adds CSR read-modify-write ops, WARL field masking, illegal-access detection, trap entry/MRET state updates, interrupt pending/selection and 64-bit cycle/instret counters. Sits beside the execute stage: the decoder drives CSR accesses, the trap controller drives trap/mret, and the fetch unit consumes trap_vector/mepc.

Parameters:
XLEN, 32, data width (32 only; mcycleh/minstreth exist only for XLEN=32)
COUNTER_W, 64, width of mcycle/minstret counters
MTVEC_RESET, 32'h0000_0000, mtvec reset value (mode bits taken from it)
MISA_VALUE, 32'h4000_0100, read-only misa value (RV32I)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
csr_en  in  1  CSR access this cycle
csr_op  in  2  0=none, 1=RW, 2=RS (set), 3=RC (clear)
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  operand (rs1 or zimm)
csr_rdata  out  XLEN  old CSR value, combinational
csr_illegal  out  1  access is illegal, combinational
instret  in  1  one instruction retired this cycle
trap_valid  in  1  take trap this cycle
trap_cause  in  XLEN  mcause value (bit31 = interrupt)
trap_pc  in  XLEN  PC to save in mepc
mret  in  1  execute MRET this cycle
irq_sw, irq_timer, irq_ext  in  1 each  interrupt lines, level
irq_pending  out  1  enabled interrupt pending and mstatus.MIE=1
irq_cause  out  XLEN  cause of highest-priority pending interrupt
trap_vector  out  XLEN  target PC for current trap_cause
mepc_o  out  XLEN  current mepc

Behaviour:
- Reset (rst_n low, async): mstatus=0x0000_1800 (MPP hardwired 2'b11, MIE=MPIE=0), mie=0, mip=0, mscratch=0, mepc=0, mcause=0, mtvec=MTVEC_RESET with bit1 cleared, counters=0. irq_pending=0; remaining outputs follow registers.
- Map: mstatus 0x300, misa 0x301 (RO), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mhartid 0xF14 (RO, 0).
- Read: csr_rdata = current value whenever csr_en; 0 when unmapped or !csr_en.
- New value: RW -> wdata; RS -> old|wdata; RC -> old&~wdata; then WARL mask, written at next clk edge.
- WARL: mstatus writable bits 3, 7 only; mie bits 3, 7, 11 only; mtvec bit1 forced 0; mepc bits[1:0] forced 0; mip read-only (writes ignored, not illegal).
- csr_illegal=1 when csr_en and: address unmapped; or address in 0xC00-0xFFF read-only space (mhartid) or misa with op RW, or RS/RC with wdata!=0. Illegal access updates nothing.
- mip: bits 3/7/11 register irq_sw/irq_timer/irq_ext each cycle (1-cycle latency).
- irq_pending = mstatus.MIE & |(mip & mie). irq_cause priority ext (0x8000_000B) > sw (0x8000_0003) > timer (0x8000_0007); 0 when none pending.
- trap_vector: mtvec mode 0 -> base; mode 1 and trap_cause[31] -> base + 4*trap_cause[4:0]; mode 1 exception -> base. base = mtvec & ~3.
- Trap (trap_valid): mepc<=trap_pc&~3, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
- MRET: MIE<=MPIE, MPIE<=1.
- Same-cycle priority: trap > mret > CSR write. Losing CSR write to a trap-affected CSR is dropped; a write to an unaffected CSR in a trap cycle still occurs. trap_valid and mret together: trap wins, mret ignored.
- Counters: mcycle +1 every cycle; minstret +1 when instret. Write to low/high half replaces that half and suppresses increment that cycle; wrap 2^64-1 -> 0; low-half overflow carries into high half.

Decomposition:
- csr_pkg: CSR address constants, csr_op_t enum, mstatus/mip bit index constants, interrupt cause constants, WARL mask constants.
- Sub-module csr_counter (COUNTER_W, lo/hi write enable, inc): instantiated twice for mcycle and minstret.

Test Plan:
- Reset release, read 0x300 -> 0x0000_1800; read 0x305 -> MTVEC_RESET&~2; read 0x7C0 -> rdata 0, illegal=1.
- RW 0x340=0xDEAD_BEEF, RS 0x0000_0010, RC 0x0000_000F -> reads 0xDEAD_BEEF, 0xDEAD_BEFF, 0xDEAD_BEF0.
- RW mstatus=0xFFFF_FFFF -> read 0x0000_1888; RW 0xF14 -> illegal, value stays 0; RS misa wdata=0 -> legal, reads MISA_VALUE.
- MIE=1, mie=0x800, irq_ext high -> irq_pending 1 cycle later, irq_cause=0x8000_000B; mtvec=0x1001, trap cause 0x8000_000B -> trap_vector=0x102C; after trap MIE=0, MPIE=1; MRET -> MIE=1.
- Trap with trap_pc=0x203 and simultaneous RW mepc=0x500 -> mepc=0x200.
- mcycle RW 0xFFFF_FFFF -> next cycle mcycleh=1, mcycle=0; minstret counts exactly 3 pulses of instret.
